// File: rtl/i2c_passthru_pkg.sv
// i2c_passthru_pkg: shared recovery state encodings and default f_ref timing constants
package i2c_passthru_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHECK     = 4'd1,
        ST_SCL_LOW   = 4'd2,
        ST_SCL_WAIT  = 4'd3,
        ST_SCL_HIGH  = 4'd4,
        ST_STOP_LOW  = 4'd5,
        ST_STOP_HIGH = 4'd6,
        ST_STOP_REL  = 4'd7,
        ST_DONE      = 4'd8,
        ST_FAIL      = 4'd9
    } rec_state_t;

    localparam int DEF_F_REF_T_HALF        = 38;
    localparam int DEF_WIDTH_F_REF_T_HALF  = 6;
    localparam int DEF_F_REF_T_STRETCH_MAX = 255;
    localparam int DEF_WIDTH_F_REF_STRETCH = 8;
    localparam int DEF_RECOVERY_PULSES     = 9;
    localparam int DEF_WIDTH_PULSES        = 4;

endpackage

// File: rtl/i2c_passthru_ref_timer.sv
// i2c_passthru_ref_timer: loadable down-counter ticking on i_f_ref rising edges
//   i_clk, i_rst    : clock, synchronous active-high reset (count -> 0)
//   i_f_ref         : timing reference, one rising edge = one tick
//   i_load          : load i_load_val (wins over a tick)
//   o_tc            : count is zero
module i2c_passthru_ref_timer
    import i2c_passthru_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH_F_REF_T_HALF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_f_ref,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic             f_ref_q;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge i_clk)
        f_ref_q <= i_f_ref;

    always_ff @(posedge i_clk)
        if (i_rst)
            cnt <= '0;
        else if (i_load)
            cnt <= i_load_val;
        else if (i_f_ref && !f_ref_q && cnt != '0)
            cnt <= cnt - 1'b1;

    assign o_tc = cnt == '0;

endmodule

// File: rtl/i2c_passthru_bus_recovery.sv
// i2c_passthru_bus_recovery: clocks SCL to free a target holding SDA low, then optional STOP
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_en                : enable; low aborts any sequence
//   i_f_ref             : timing reference (rising edge = one pulse)
//   i_stuck             : stuck flag from the idle/stuck detector (rising edge starts)
//   i_sda, i_scl        : synchronized bus levels
//   o_scl_oe, o_sda_oe  : 1 = pull line low
//   o_busy              : sequence running, passthru must suspend forwarding
//   o_done, o_fail      : one-cycle result pulses
// Config: I2C_PASSTHRU_RECOVERY_STOP_EN enables the STOP sequence; otherwise a released
// SDA goes straight to ST_DONE and o_sda_oe is tied low.
module i2c_passthru_bus_recovery
    import i2c_passthru_pkg::*;
#(
    parameter int F_REF_T_HALF        = DEF_F_REF_T_HALF,
    parameter int WIDTH_F_REF_T_HALF  = DEF_WIDTH_F_REF_T_HALF,
    parameter int F_REF_T_STRETCH_MAX = DEF_F_REF_T_STRETCH_MAX,
    parameter int WIDTH_F_REF_STRETCH = DEF_WIDTH_F_REF_STRETCH,
    parameter int RECOVERY_PULSES     = DEF_RECOVERY_PULSES,
    parameter int WIDTH_PULSES        = DEF_WIDTH_PULSES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_f_ref,
    input  logic i_stuck,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_scl_oe,
    output logic o_sda_oe,
    output logic o_busy,
    output logic o_done,
    output logic o_fail
);

    localparam logic [WIDTH_F_REF_T_HALF-1:0]  HALF_LD    = WIDTH_F_REF_T_HALF'(F_REF_T_HALF);
    localparam logic [WIDTH_F_REF_STRETCH-1:0] STRETCH_LD = WIDTH_F_REF_STRETCH'(F_REF_T_STRETCH_MAX);
    localparam logic [WIDTH_PULSES-1:0]        PULSES_MAX = WIDTH_PULSES'(RECOVERY_PULSES);
`ifdef I2C_PASSTHRU_RECOVERY_STOP_EN
    localparam rec_state_t ST_STOP = ST_STOP_LOW;
`else
    localparam rec_state_t ST_STOP = ST_DONE;
`endif

    rec_state_t              state, state_nxt;
    logic [WIDTH_PULSES-1:0] pulse_cnt, pulse_nxt, pulse_inc;
    logic                    stuck_q, half_tc, stretch_tc, load;

    // Both timers restart on every state change, so each phase times from its own entry.
    assign load      = state_nxt != state;
    assign pulse_inc = pulse_cnt == PULSES_MAX ? pulse_cnt : pulse_cnt + 1'b1;

    i2c_passthru_ref_timer #(.WIDTH(WIDTH_F_REF_T_HALF)) u_half (
        .i_clk(i_clk), .i_rst(i_rst), .i_f_ref(i_f_ref),
        .i_load(load), .i_load_val(HALF_LD), .o_tc(half_tc)
    );

    i2c_passthru_ref_timer #(.WIDTH(WIDTH_F_REF_STRETCH)) u_stretch (
        .i_clk(i_clk), .i_rst(i_rst), .i_f_ref(i_f_ref),
        .i_load(load), .i_load_val(STRETCH_LD), .o_tc(stretch_tc)
    );

    always_ff @(posedge i_clk)
        stuck_q <= i_stuck;

    always_ff @(posedge i_clk)
        if (i_rst) begin
            state     <= ST_IDLE;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= pulse_nxt;
        end

    always_comb begin
        state_nxt = state;
        pulse_nxt = pulse_cnt;
        if (state != ST_IDLE && !i_en)
            state_nxt = ST_IDLE;
        else
            case (state)
                ST_IDLE:      state_nxt = i_stuck && !stuck_q && i_en ? ST_CHECK : ST_IDLE;
                ST_CHECK: begin
                    state_nxt = !i_scl ? ST_FAIL : i_sda ? ST_STOP : ST_SCL_LOW;
                    pulse_nxt = '0;
                end
                ST_SCL_LOW:   state_nxt = half_tc ? ST_SCL_WAIT : ST_SCL_LOW;
                ST_SCL_WAIT:  state_nxt = i_scl ? ST_SCL_HIGH : stretch_tc ? ST_FAIL : ST_SCL_WAIT;
                ST_SCL_HIGH:
                    if (half_tc) begin
                        pulse_nxt = pulse_inc;
                        state_nxt = i_sda ? ST_STOP : pulse_inc == PULSES_MAX ? ST_FAIL : ST_SCL_LOW;
                    end
`ifdef I2C_PASSTHRU_RECOVERY_STOP_EN
                ST_STOP_LOW:  state_nxt = half_tc ? ST_STOP_HIGH : ST_STOP_LOW;
                ST_STOP_HIGH: state_nxt = half_tc && i_scl ? ST_STOP_REL : ST_STOP_HIGH;
                ST_STOP_REL:  state_nxt = !half_tc ? ST_STOP_REL : i_sda && i_scl ? ST_DONE : ST_FAIL;
`endif
                default:      state_nxt = ST_IDLE;
            endcase
    end

    assign o_scl_oe = state == ST_SCL_LOW || state == ST_STOP_LOW;
`ifdef I2C_PASSTHRU_RECOVERY_STOP_EN
    assign o_sda_oe = state == ST_STOP_LOW || state == ST_STOP_HIGH;
`else
    assign o_sda_oe = 1'b0;
`endif
    assign o_busy   = state != ST_IDLE;
    assign o_done   = state == ST_DONE;
    assign o_fail   = state == ST_FAIL;

endmodule
